// File: rtl/fe_pkg.sv
// Shared types and helpers for the RV32I fetch front-end.
// The instruction-queue entry is built from FE_XLEN, so the top's XLEN must match it.
package fe_pkg;

  localparam int          FE_XLEN     = 32;
  localparam logic [31:0] FE_RESET_PC = 32'h0040_0000;

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    WAIT,
    FLUSH,
    HALTED
  } fe_fetch_state_t;

  typedef enum logic [6:0] {
    R_TYPE       = 7'b0110011,
    I_TYPE       = 7'b0010011,
    I_LOAD_TYPE  = 7'b0000011,
    I_JALR_TYPE  = 7'b1100111,
    I_ENV_TYPE   = 7'b1110011,
    S_TYPE       = 7'b0100011,
    B_TYPE       = 7'b1100011,
    U_LUI_TYPE   = 7'b0110111,
    U_AUIPC_TYPE = 7'b0010111,
    J_TYPE       = 7'b1101111
  } RV32I_OPCODE_t;

  typedef struct packed {
    logic [31:0]        instr;
    logic [FE_XLEN-1:0] pc;
  } fe_ibuf_entry_t;

  function automatic logic fe_is_legal_opcode(input logic [6:0] op);
    case (op)
      R_TYPE, I_TYPE, I_LOAD_TYPE, I_JALR_TYPE, I_ENV_TYPE,
      S_TYPE, B_TYPE, U_LUI_TYPE, U_AUIPC_TYPE, J_TYPE: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fe_ibuf.sv
// Small synchronous FIFO holding fetched instructions; head is visible combinationally.
// Flush empties the queue in one cycle and overrides any push/pop in the same cycle.
module fe_ibuf #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers are PTR_W wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fe_fetch_ctrl.sv
// RV32I fetch sequencer: owns the PC, keeps one imem request in flight at most,
// queues responses for decode, and handles redirects and sticky halt requests.
module fe_fetch_ctrl
  import fe_pkg::*;
#(
  parameter int             XLEN       = FE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = FE_RESET_PC,
  parameter int             IBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output RV32I_OPCODE_t   dec_opcode,
  output logic            dec_illegal,
  output logic            halted
);

  localparam int CNT_W = $clog2(IBUF_DEPTH) + 1;

  fe_fetch_state_t r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic            r_outstanding, w_outstanding_next;
  logic            r_halt_pending, w_halt_pending_next;

  logic            w_req_valid;
  logic            w_hs;
  logic            w_rsp_take;
  logic            w_halt_now;
  logic            w_push;
  logic            w_flush;
  logic            w_credit_ok;
  logic [CNT_W:0]  w_inflight;
  logic [CNT_W-1:0] w_count;
  logic [XLEN-1:0] w_redirect_target;
  fe_ibuf_entry_t  w_push_entry;
  fe_ibuf_entry_t  w_head_entry;

  // Queue slots already claimed by buffered entries plus the request in flight.
  assign w_inflight        = {1'b0, w_count} + {{CNT_W{1'b0}}, r_outstanding};
  assign w_credit_ok       = w_inflight < (CNT_W + 1)'(IBUF_DEPTH);
  assign w_hs              = w_req_valid && imem_req_ready;
  assign w_rsp_take        = imem_rsp_valid && r_outstanding;
  assign w_halt_now        = r_halt_pending || halt_req;
  assign w_redirect_target = redirect_pc & ~XLEN'(3);

  always_comb begin
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_outstanding_next  = r_outstanding;
    w_halt_pending_next = w_halt_now;
    w_req_valid         = 1'b0;
    w_push              = 1'b0;
    w_flush             = 1'b0;

    case (r_state)
      BOOT: w_state_next = FETCH;

      FETCH: begin
        // Only the registered halt gates new requests, so a same-cycle halt
        // lets an in-progress handshake complete.
        w_req_valid = w_credit_ok && !r_halt_pending;
        if (w_hs) begin
          w_pc_next          = r_pc + XLEN'(4);
          w_outstanding_next = 1'b1;
        end
        if (redirect_valid) begin
          w_flush      = 1'b1;
          w_pc_next    = w_redirect_target;
          w_state_next = w_hs ? FLUSH : FETCH;
        end else if (w_hs) begin
          w_state_next = WAIT;
        end else if (w_halt_now) begin
          w_state_next = HALTED;
        end
      end

      WAIT: begin
        if (w_rsp_take) w_outstanding_next = 1'b0;
        if (redirect_valid) begin
          w_flush      = 1'b1;
          w_pc_next    = w_redirect_target;
          w_state_next = w_rsp_take ? FETCH : FLUSH;
        end else if (w_rsp_take) begin
          w_push       = 1'b1;
          w_state_next = w_halt_now ? HALTED : FETCH;
        end
      end

      FLUSH: begin
        if (w_rsp_take) w_outstanding_next = 1'b0;
        if (redirect_valid) begin
          w_flush      = 1'b1;
          w_pc_next    = w_redirect_target;
          w_state_next = w_rsp_take ? FETCH : FLUSH;
        end else if (w_rsp_take) begin
          w_state_next = w_halt_now ? HALTED : FETCH;
        end
      end

      HALTED: w_state_next = HALTED;

      default: w_state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= BOOT;
      r_pc           <= RESET_PC;
      r_outstanding  <= 1'b0;
      r_halt_pending <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_outstanding  <= w_outstanding_next;
      r_halt_pending <= w_halt_pending_next;
    end
  end

  // In WAIT the PC has already advanced past the outstanding request.
  assign w_push_entry.instr = imem_rsp_data;
  assign w_push_entry.pc    = r_pc - XLEN'(4);

  fe_ibuf #(
    .DEPTH (IBUF_DEPTH),
    .WIDTH ($bits(fe_ibuf_entry_t))
  ) u_ibuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (dec_valid && dec_ready),
    .i_flush     (w_flush),
    .o_head      (w_head_entry),
    .o_count     (w_count)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign halted         = (r_state == HALTED);

  assign dec_valid   = (w_count != '0);
  assign dec_instr   = dec_valid ? w_head_entry.instr : '0;
  assign dec_pc      = dec_valid ? w_head_entry.pc : '0;
  assign dec_opcode  = RV32I_OPCODE_t'(dec_instr[6:0]);
  assign dec_illegal = dec_valid &&
                       (!fe_is_legal_opcode(dec_instr[6:0]) || (dec_instr[1:0] != 2'b11));

endmodule

// File: tb/tb_fe_fetch_ctrl.sv
// Directed scenarios plus a randomized run checked against a stream-level model:
// fetched PCs run sequentially from the last redirect, and each word matches imem.
module tb_fe_fetch_ctrl;
  import fe_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          halt_req;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_instr;
  logic [31:0]   dec_pc;
  RV32I_OPCODE_t dec_opcode;
  logic          dec_illegal;
  logic          halted;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fe_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_opcode     (dec_opcode),
    .dec_illegal    (dec_illegal),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h13;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w);
    return !(w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                            7'h23, 7'h63, 7'h37, 7'h17, 7'h6F});
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 0);
    chk({tag, "_req_addr"},  imem_req_addr, RST_PC);
    chk({tag, "_dec_valid"}, 32'(dec_valid), 0);
    chk({tag, "_dec_instr"}, dec_instr, 0);
    chk({tag, "_dec_pc"},    dec_pc, 0);
    chk({tag, "_illegal"},   32'(dec_illegal), 0);
    chk({tag, "_halted"},    32'(halted), 0);
  endtask

  // Random-phase model state
  logic [31:0] exp_req, exp_dec, pdata;
  logic        pend, prev_redir;
  int          pwait, consumed;

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mid();
    chk_reset_outputs("reset");
    nxt();
    rst_n = 1'b1; imem_req_ready = 1'b1;

    // Boot and first fetch
    mid(); chk("boot_req_valid", 32'(imem_req_valid), 0); nxt();
    mid(); chk("c1_req_valid", 32'(imem_req_valid), 1); chk("c1_req_addr", imem_req_addr, RST_PC); nxt();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    mid(); chk("wait_req_valid", 32'(imem_req_valid), 0); nxt();
    imem_rsp_valid = 1'b0;
    mid();
    chk("c3_dec_valid", 32'(dec_valid), 1);
    chk("c3_dec_pc", dec_pc, RST_PC);
    chk("c3_dec_instr", dec_instr, 32'h0050_0093);
    chk("c3_dec_opcode", 32'(dec_opcode), 32'h13);
    chk("c3_dec_illegal", 32'(dec_illegal), 0);
    chk("c3_req_addr", imem_req_addr, RST_PC + 4);
    nxt();

    // Queue full with decode stalled: fetching must stop
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    mid(); nxt();
    imem_rsp_valid = 1'b0;
    mid(); chk("credit_stall_a", 32'(imem_req_valid), 0); nxt();
    dec_ready = 1'b1;
    mid(); chk("credit_stall_b", 32'(imem_req_valid), 0); chk("fifo_head0", dec_pc, RST_PC); nxt();
    mid();
    chk("fifo_head1", dec_pc, RST_PC + 4);
    chk("fifo_head1_instr", dec_instr, 32'h0000_0013);
    chk("resume_req_valid", 32'(imem_req_valid), 1);
    chk("resume_req_addr", imem_req_addr, RST_PC + 8);
    nxt();

    // Opcode classification
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0073;
    mid(); chk("drained_dec_valid", 32'(dec_valid), 0); nxt();
    imem_rsp_valid = 1'b0;
    mid();
    chk("ecall_pc", dec_pc, RST_PC + 8);
    chk("ecall_opcode", 32'(dec_opcode), 32'h73);
    chk("ecall_illegal", 32'(dec_illegal), 0);
    chk("req_addr_c", imem_req_addr, RST_PC + 12);
    nxt();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF;
    mid(); nxt();
    imem_rsp_valid = 1'b0;
    mid(); chk("ones_illegal", 32'(dec_illegal), 1); chk("ones_pc", dec_pc, RST_PC + 12); nxt();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0000;
    mid(); nxt();
    imem_rsp_valid = 1'b0;
    mid();
    chk("zero_valid", 32'(dec_valid), 1);
    chk("zero_illegal", 32'(dec_illegal), 1);
    chk("zero_instr", dec_instr, 0);
    nxt();

    // Redirect while a request is outstanding
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0102; dec_ready = 1'b0;
    mid(); nxt();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    mid(); chk("flush_dec_valid", 32'(dec_valid), 0); chk("flush_req_valid", 32'(imem_req_valid), 0); nxt();
    imem_rsp_valid = 1'b0;
    mid(); chk("redir_req_valid", 32'(imem_req_valid), 1); chk("redir_req_addr", imem_req_addr, 32'h0040_0100); nxt();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    mid(); nxt();

    // Redirect coinciding with a handshake and a stray response
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
    mid();
    chk("redir_dec_pc", dec_pc, 32'h0040_0100);
    chk("redir2_req_addr", imem_req_addr, 32'h0040_0104);
    nxt();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    mid(); chk("redir2_flushed", 32'(dec_valid), 0); chk("redir2_req_valid", 32'(imem_req_valid), 0); nxt();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    mid(); chk("redir2_drop_req_valid", 32'(imem_req_valid), 0); nxt();

    // Halt from FETCH with no handshake
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; halt_req = 1'b1;
    mid();
    chk("redir2_req_addr2", imem_req_addr, 32'h0040_0200);
    chk("redir2_dropped", 32'(dec_valid), 0);
    nxt();
    halt_req = 1'b0; imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid(); chk("halted_flag", 32'(halted), 1); chk("halted_no_req", 32'(imem_req_valid), 0); nxt();
    end

    // Asynchronous reset during WAIT, then a stale response
    rst_n = 1'b0; #1;
    chk_reset_outputs("rst_halted");
    nxt();
    rst_n = 1'b1;
    mid(); nxt();
    mid(); chk("rst2_req_valid", 32'(imem_req_valid), 1); nxt();
    rst_n = 1'b0; #1;
    chk_reset_outputs("rst_wait");
    nxt();
    rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    mid(); nxt();
    mid(); chk("stale_req_addr", imem_req_addr, RST_PC); chk("stale_req_valid", 32'(imem_req_valid), 1); nxt();
    imem_rsp_valid = 1'b0;
    mid(); chk("stale_ignored_a", 32'(dec_valid), 0); nxt();
    mid(); chk("stale_ignored_b", 32'(dec_valid), 0); nxt();

    // Randomized run against the stream model
    rst_n = 1'b0; #1; nxt();
    rst_n = 1'b1;
    exp_req = RST_PC; exp_dec = RST_PC; pend = 1'b0; pwait = 0; pdata = '0;
    prev_redir = 1'b0; consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = RST_PC + 32'($urandom_range(0, 1023));
      if (pend && pwait == 0) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = pdata;
      end else begin
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'($urandom);
        if (pend) pwait--;
      end
      mid();
      if (prev_redir) chk("rnd_flush_empty", 32'(dec_valid), 0);
      if (imem_rsp_valid) pend = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        chk("rnd_req_addr", imem_req_addr, exp_req);
        chk("rnd_single_outstanding", 32'(pend), 0);
        pend = 1'b1; pwait = int'($urandom_range(0, 2)); pdata = mem_word(imem_req_addr);
        exp_req = exp_req + 4;
      end
      if (dec_valid && dec_ready && !redirect_valid) begin
        chk("rnd_dec_pc", dec_pc, exp_dec);
        chk("rnd_dec_instr", dec_instr, mem_word(exp_dec));
        chk("rnd_dec_opcode", 32'(dec_opcode), 32'(mem_word(exp_dec) & 32'h7F));
        chk("rnd_dec_illegal", 32'(dec_illegal), 32'(ref_illegal(mem_word(exp_dec))));
        exp_dec = exp_dec + 4;
        consumed++;
      end
      if (redirect_valid) begin
        exp_req = redirect_pc & ~32'h3;
        exp_dec = redirect_pc & ~32'h3;
      end
      prev_redir = redirect_valid;
      nxt();
    end
    chk("rnd_progress", 32'(consumed > 100), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fe_fetch_ctrl.md
Name: fe_fetch_ctrl

Overview:
Instruction-fetch sequencer for the RV32I front-end. It owns the PC, issues requests to instruction memory over a valid/ready handshake with at most one request outstanding, and buffers responses in a small instruction queue. It presents the instruction, its PC and the decoded opcode class to decode, and handles redirects from branch/jump resolution and halt requests from ECALL/EBREAK handling.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0040_0000, PC loaded on reset
IBUF_DEPTH, 2, instruction queue entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  XLEN  fetch address, word aligned
imem_rsp_valid  in  1  response valid, earliest 1 cycle after request handshake
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  branch/jump taken
redirect_pc  in  XLEN  redirect target
halt_req  in  1  stop fetching; sticky until reset
dec_valid  out  1  head of queue valid
dec_ready  in  1  decode consumes head
dec_instr  out  32  instruction at head
dec_pc  out  XLEN  PC of dec_instr
dec_opcode  out  7  dec_instr[6:0], typed RV32I_OPCODE_t
dec_illegal  out  1  head opcode not a legal RV32I_OPCODE_t value, or instr[1:0]!=2'b11
halted  out  1  controller in HALTED

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, port rst_n.
- Reset values: pc=RESET_PC, state=BOOT, queue empty, outstanding=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, dec_illegal=0, halted=0.
- Credit rule: a request may issue only if count+outstanding < IBUF_DEPTH. The queue can never overflow.
- BOOT: one cycle, then FETCH.
- FETCH: imem_req_valid=(credit ok), imem_req_addr=pc. On handshake: pc<=pc+4, outstanding<=1, go to WAIT. imem_req_valid stays asserted until handshake unless a redirect or halt occurs.
- WAIT: imem_req_valid=0. On imem_rsp_valid: push {rsp_data, pc_of_req} into the queue, outstanding<=0, go to FETCH.
- FLUSH: waits for the response of the discarded request. On imem_rsp_valid: drop it, go to FETCH. No push.
- HALTED: no requests. An outstanding response is still pushed. The queue drains normally. halted=1. Only reset exits.
- Priority: redirect > halt > normal.
- Redirect (any state except BOOT/HALTED):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Queue is flushed; dec_valid=0 from the next cycle.
  - Next state is FLUSH if a request is outstanding and its response does not arrive this cycle, or if a request handshakes this same cycle. Otherwise FETCH.
  - A response arriving in the redirect cycle is dropped.
- halt_req: finish the current handshake and its response, then enter HALTED. halt_req in FETCH with no handshake goes straight to HALTED.
- Queue:
  - dec_* reflect the head entry; dec_valid = count!=0.
  - Pop when dec_valid&&dec_ready.
  - Push and pop in the same cycle are allowed.
  - Order is strictly FIFO.
  - Pointers wrap modulo IBUF_DEPTH.
- A response with outstanding=0 is ignored.
- Timing: first request in cycle 1 after reset release. Zero-wait imem gives first dec_valid in cycle 3. Peak throughput is 1 instruction per 2 cycles.
- pc arithmetic is modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0.
- Reset mid-operation: all state clears asynchronously. A stale response after release is ignored because outstanding=0.

Decomposition:
- fe_pkg additions:
  - fe_fetch_state_t {BOOT, FETCH, WAIT, FLUSH, HALTED}
  - FE_RESET_PC constant
  - function fe_is_legal_opcode(logic[6:0]), returning 1 for the 10 RV32I_OPCODE_t values
  - typedef fe_ibuf_entry_t {instr, pc}
- One sub-module: fe_ibuf, a parameterised synchronous FIFO with push, pop, count and flush.

Test Plan:
- Boot, imem always ready, 1-cycle rsp 0x00500093 -> req addr 0x00400000 in cycle 1; dec_valid cycle 3 with dec_pc=0x00400000, dec_opcode=I_TYPE, dec_illegal=0.
- dec_ready=0, imem returns 0x00000013 each time -> exactly 2 requests (0x00400000, 0x00400004), then imem_req_valid=0. Raising dec_ready pops in order and fetch resumes at 0x00400008.
- Redirect to 0x00400102 while in WAIT -> next response dropped, dec_valid=0, next req addr 0x00400100, delivered dec_pc=0x00400100.
- Redirect to 0x00400200 in the same cycle as a request handshake and rsp_valid -> both responses dropped (FLUSH consumes the later one), next req addr 0x00400200.
- Responses 0xFFFFFFFF and 0x00000000 -> dec_illegal=1 for both; 0x00000073 -> dec_opcode=I_ENV_TYPE, dec_illegal=0.
- rst_n low during WAIT, late rsp_valid after release -> outputs at reset values immediately, late response ignored, req addr=0x00400000. halt_req in FETCH -> halted=1, no further requests.
